// File: rtl/onn_phase_readout.sv
// rtl/onn_phase_readout.sv - ONN phase binarisation, stability detection and convergence/timeout readout (optional PHASE_TOL_EN)
module onn_phase_readout #(
    parameter int N          = 15,
    parameter int PW         = 4,
    parameter int STABLE_CNT = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              full_tick,
    input  logic [N*PW-1:0]   phi_in,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timed_out,
    output logic [N-1:0]      pattern,
    output logic [7:0]        period_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [PW-1:0] Q1 = PW'(2 ** (PW - 2));
    localparam logic [PW-1:0] Q3 = PW'(3 * (2 ** (PW - 2)));

    state_t               state, state_nxt;
    logic [N-1:0][PW-1:0] rel;
    logic [N-1:0]         b_cur, b_prev;
    logic [3:0]           stab_cnt, stab_nxt;
    logic [7:0]           cnt_nxt;
    logic                 tol_ok, match, conv_hit, tmo_hit, sample, launch;

    assign sample = (state == RUN) && full_tick;
    assign launch = start && (state != RUN);

    // Relative phase of each lane against neuron 0, binarised to in/anti-phase
    always_comb begin
        rel   = '0;
        b_cur = '0;
        for (int i = 0; i < N; i++) begin
            rel[i]   = phi_in[i*PW +: PW] - phi_in[0 +: PW];
            b_cur[i] = (rel[i] >= Q1) && (rel[i] < Q3);
        end
        b_cur[0] = 1'b0;
    end

`ifdef PHASE_TOL_EN
    logic [N-1:0][PW-1:0] rel_prev;
    logic [PW-1:0]        step;

    // Every lane's relative phase must stay within one step of its last sample
    always_comb begin
        tol_ok = 1'b1;
        step   = '0;
        for (int i = 0; i < N; i++) begin
            step = rel[i] - rel_prev[i];
            if (!(step == '0 || step == PW'(1) || step == {PW{1'b1}}))
                tol_ok = 1'b0;
        end
    end

    // Relative phase history for the tolerance check
    always_ff @(posedge clk) begin
        if (rst)
            rel_prev <= '0;
        else if (sample)
            rel_prev <= rel;
    end
`else
    assign tol_ok = 1'b1;
`endif

    // Per-tick counter updates and the convergence/timeout decisions
    always_comb begin
        cnt_nxt  = (period_cnt == 8'hFF) ? period_cnt : period_cnt + 8'd1;
        match    = (b_cur == b_prev) && tol_ok;
        stab_nxt = (period_cnt == 8'd0 || !match) ? 4'd1 : stab_cnt + 4'd1;
        conv_hit = sample && (stab_nxt == 4'(STABLE_CNT));
        tmo_hit  = sample && !conv_hit && (cnt_nxt >= 8'(TIMEOUT));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (conv_hit || tmo_hit) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and run bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
            timed_out  <= 1'b0;
            pattern    <= '0;
            period_cnt <= '0;
            stab_cnt   <= '0;
            b_prev     <= '0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= 1'b0;
            if (launch) begin
                converged  <= 1'b0;
                timed_out  <= 1'b0;
                pattern    <= '0;
                period_cnt <= '0;
                stab_cnt   <= '0;
                b_prev     <= '0;
            end else if (sample) begin
                period_cnt <= cnt_nxt;
                stab_cnt   <= stab_nxt;
                b_prev     <= b_cur;
                if (conv_hit) begin
                    pattern   <= b_cur;
                    converged <= 1'b1;
                    done      <= 1'b1;
                end else if (tmo_hit) begin
                    pattern   <= b_cur;
                    timed_out <= 1'b1;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule
